// File: rtl/font_text_reader.sv
// font_text_reader: maps VGA pixel coordinates to font ROM rows for "ISA" and selects the glyph bit.
// Optional macro FONT_BLINK_EN adds a 64-frame blink (32 shown, 32 hidden).
module font_text_reader #(
    parameter int unsigned X0       = 288,
    parameter int unsigned Y0       = 232,
    parameter int unsigned NCHAR    = 3,
    parameter logic [2:0]  FG_COLOR = 3'b111,
    parameter logic [2:0]  BG_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       text_on,
    output logic [2:0] rgb
);
    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XH = 10'(X0 + 8 * NCHAR);
    localparam logic [9:0] YL = 10'(Y0);
    localparam logic [9:0] YH = 10'(Y0 + 16);

    logic [5:0] rom_addr_q, rom_addr_d;
    logic [2:0] bit_sel_q, bit_sel_d;
    logic [2:0] rgb_q, rgb_d;
    logic       win_q, win_d, vid_q, vid_d, text_on_q, text_on_d;
    logic [4:0] dx;
    logic [3:0] dy;
    logic       in_win, pix, vis;

`ifdef FONT_BLINK_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pixel_tick && pixel_x == 10'd0 && pixel_y == 10'd0)
            frame_cnt_d = frame_cnt_q + 6'd1;
        vis = ~frame_cnt_q[5];
    end
    always_ff @(posedge clk) begin
        if (reset) frame_cnt_q <= 6'd0;
        else       frame_cnt_q <= frame_cnt_d;
    end
`else
    always_comb vis = 1'b1;
`endif

    always_comb begin
        // Only the low bits of the offsets are needed: glyph index and glyph row.
        dx         = pixel_x[4:0] - XL[4:0];
        dy         = pixel_y[3:0] - YL[3:0];
        in_win     = pixel_x >= XL && pixel_x < XH && pixel_y >= YL && pixel_y < YH;
        pix        = rom_data[3'd7 - bit_sel_q] & win_q & vis;
        rom_addr_d = rom_addr_q;
        bit_sel_d  = bit_sel_q;
        win_d      = win_q;
        vid_d      = vid_q;
        text_on_d  = text_on_q;
        rgb_d      = rgb_q;
        if (pixel_tick) begin
            rom_addr_d = in_win ? {dx[4:3] + 2'd1, dy} : 6'h00;
            bit_sel_d  = dx[2:0];
            win_d      = in_win;
            vid_d      = video_on;
            text_on_d  = pix & vid_q;
            rgb_d      = !vid_q ? 3'b000 : (pix ? FG_COLOR : BG_COLOR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q <= 6'h00;
            bit_sel_q  <= 3'd0;
            win_q      <= 1'b0;
            vid_q      <= 1'b0;
            text_on_q  <= 1'b0;
            rgb_q      <= 3'b000;
        end else begin
            rom_addr_q <= rom_addr_d;
            bit_sel_q  <= bit_sel_d;
            win_q      <= win_d;
            vid_q      <= vid_d;
            text_on_q  <= text_on_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign text_on  = text_on_q;
    assign rgb      = rgb_q;
endmodule
